mips_cpu_hilo_unit: RTL and testbench
=====================================

Name: mips_cpu_hilo_unit

Overview:
- Multi-cycle HI/LO execution unit for the MIPS CPU. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and owns the architectural HI and LO registers.
- Drives the external combinational 32x32 multiplier, registers its 64-bit product into {HI,LO}, and contains its own 32-iteration restoring divider.
- The pipeline stalls MFHI/MFLO and new HI/LO ops on busy.

Parameters:
- MULT_STAGES, 2, cycles from MULT/MULTU acceptance to HI/LO commit. Legal range 1..15. Gives the external multiplier a settle window.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  operation request
- op  in  3  opcode: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
- op_a  in  32  rs operand (dividend / multiplicand / MTxx data)
- op_b  in  32  rt operand (divisor / multiplier)
- op_ready  out  1  unit can accept (state IDLE)
- busy  out  1  MULT or DIV in progress
- done  out  1  one-cycle pulse: HI/LO just committed, or div-by-zero finished
- div_by_zero  out  1  one-cycle pulse coincident with done for DIV/DIVU with op_b==0
- mul_a  out  32  registered operand to multiplier a
- mul_b  out  32  registered operand to multiplier b
- mul_sign  out  1  registered signed-mode to multiplier
- mul_out  in  64  multiplier product {hi,lo}
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (reset==0, async): state IDLE, hi=lo=0, mul_a=mul_b=0, mul_sign=0, busy=0, done=0, div_by_zero=0, counters 0, op_ready=1. A reset mid-operation aborts the operation; no partial commit.
- Handshake:
  - An op is accepted on a rising edge when op_valid && op_ready.
  - op_ready = (state==IDLE).
  - op_valid while busy is ignored; it is not queued.
- FSM states: IDLE, MUL, DIV, DZ.
- MTHI/MTLO: hi (or lo) <= op_a on the accept edge. State stays IDLE. No busy, no done.
- Reserved ops 6/7: accepted, no state change, no done.
- MULT/MULTU:
  - Accept edge: mul_a<=op_a, mul_b<=op_b, mul_sign<=(op==0), cnt<=MULT_STAGES-1, go to MUL.
  - In MUL: cnt decrements each edge. On the edge where cnt==0, {hi,lo}<=mul_out, go to IDLE, done=1 for the following cycle.
  - Total: commit occurs MULT_STAGES edges after accept.
- DIV/DIVU with op_b!=0:
  - Accept edge: latch the magnitudes |a| and |b|. Signed mode uses two's-complement absolute values; unsigned mode uses them raw. Record the quotient sign (a[31]^b[31]) and remainder sign (a[31]) when signed. Clear the 33-bit partial remainder. Go to DIV.
  - DIV: 32 iterations, one quotient bit per edge, MSB first, restoring: shift, trial subtract, keep if non-negative.
  - Edge 33 after accept: apply signs (quotient negated if qsign, remainder negated if rsign), lo<=quotient, hi<=remainder, go to IDLE, done=1 next cycle.
  - 0x80000000 / 0xFFFFFFFF signed yields lo=0x80000000, hi=0. No trap.
- DIV/DIVU with op_b==0: accept edge goes to DZ. Next edge returns to IDLE with done=1 and div_by_zero=1 for one cycle. hi/lo unchanged.
- busy=1 in states MUL, DIV, DZ. busy drops on the commit edge, so op_ready=1 in the same cycle as done; back-to-back ops are accepted there.
- hi/lo outputs are registered, never combinational from mul_out.
- Product width: full 64 bits stored. Divider arithmetic uses 33-bit subtraction to avoid borrow loss at |b|>=2^31.

Test Plan:
- Reset: assert reset low mid-cycle, no clock edge -> hi=lo=0, busy=0, op_ready=1, done=0 immediately.
- MULT 0xFFFFFFFE*0x00000003, MULT_STAGES=2 -> 2 edges after accept hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulse 1 cycle. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV -7/2 (0xFFFFFFF9, 0x2) -> 33 edges after accept lo=0xFFFFFFFD, hi=0xFFFFFFFF, busy high 33 cycles. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 with hi=0x11, lo=0x22 -> busy 1 cycle, then done=div_by_zero=1 for one cycle, hi=0x11, lo=0x22 unchanged.
- During DIV, op_valid with MTHI 0xABCD -> ignored, hi reflects only the division result. Then MTLO 0x1234 in the done cycle -> accepted, lo=0x1234 next edge.
- Reset asserted at DIV iteration 10 -> busy=0, hi=lo=0 asynchronously, no done pulse after release.

Source files
------------

// File: rtl/mips_cpu_hilo_unit.sv
// HI/LO execution unit: MTHI/MTLO, multiply via an external combinational
// multiplier with a configurable settle window, and a 32-iteration restoring
// divider. Owns the architectural HI and LO registers.
module mips_cpu_hilo_unit #(
    parameter int unsigned MULT_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        op_ready,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_sign,
    input  logic [63:0] mul_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DZ} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [5:0]  dcnt;
    logic [31:0] dvsr;
    logic [31:0] quo;
    logic [32:0] rem;
    logic        qsign, rsign;

    logic        accept;
    logic        div_signed;
    logic [31:0] a_mag, b_mag;
    logic [32:0] rem_sh;
    logic        fits;
    logic [31:0] q_fin, r_fin;

    assign accept   = op_valid && (state == IDLE);
    assign op_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Operand magnitudes, one restoring step and the sign-corrected results
    always_comb begin
        div_signed = (op == OP_DIV);
        a_mag      = (div_signed && op_a[31]) ? -op_a : op_a;
        b_mag      = (div_signed && op_b[31]) ? -op_b : op_b;
        // Partial remainder stays below the divisor, so the shifted value fits
        // in 33 bits and a plain compare decides the quotient bit.
        rem_sh     = {rem[31:0], quo[31]};
        fits       = (rem_sh >= {1'b0, dvsr});
        q_fin      = qsign ? -quo : quo;
        r_fin      = rsign ? -rem[31:0] : rem[31:0];
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT, OP_MULTU: state_nxt = MUL;
                        OP_DIV, OP_DIVU:   state_nxt = (op_b == '0) ? DZ : DIV;
                        default:           state_nxt = IDLE;
                    endcase
                end
            end
            MUL:     if (cnt == '0) state_nxt = IDLE;
            DIV:     if (dcnt == 6'd32) state_nxt = IDLE;
            DZ:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, divider iterations and HI/LO commits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi          <= '0;
            lo          <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_sign    <= 1'b0;
            cnt         <= '0;
            dcnt        <= '0;
            dvsr        <= '0;
            quo         <= '0;
            rem         <= '0;
            qsign       <= 1'b0;
            rsign       <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                mul_a    <= op_a;
                                mul_b    <= op_b;
                                mul_sign <= (op == OP_MULT);
                                cnt      <= 4'(MULT_STAGES - 1);
                            end
                            OP_DIV, OP_DIVU: begin
                                quo   <= a_mag;
                                dvsr  <= b_mag;
                                rem   <= '0;
                                dcnt  <= '0;
                                qsign <= div_signed && (op_a[31] ^ op_b[31]);
                                rsign <= div_signed && op_a[31];
                            end
                            OP_MTHI: hi <= op_a;
                            OP_MTLO: lo <= op_a;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    if (cnt == '0) begin
                        {hi, lo} <= mul_out;
                        done     <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DIV: begin
                    if (dcnt == 6'd32) begin
                        lo   <= q_fin;
                        hi   <= r_fin;
                        done <= 1'b1;
                    end else begin
                        rem  <= fits ? (rem_sh - {1'b0, dvsr}) : rem_sh;
                        quo  <= {quo[30:0], fits};
                        dcnt <= dcnt + 6'd1;
                    end
                end
                DZ: begin
                    done        <= 1'b1;
                    div_by_zero <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_hilo_unit.sv
// Self-checking bench for mips_cpu_hilo_unit: directed cases plus randomized
// ops checked against an arithmetic reference model of HI/LO.
module tb_mips_cpu_hilo_unit;

    localparam int unsigned STAGES = 2;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] op_a, op_b;
    logic        op_ready, busy, done, div_by_zero;
    logic [31:0] mul_a, mul_b;
    logic        mul_sign;
    logic [63:0] mul_out;
    logic [31:0] hi, lo;

    int          total = 0;
    int          bad = 0;
    logic [31:0] m_hi, m_lo;

    mips_cpu_hilo_unit #(.MULT_STAGES(STAGES)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op          (op),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_ready    (op_ready),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_sign    (mul_sign),
        .mul_out     (mul_out),
        .hi          (hi),
        .lo          (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External combinational multiplier
    always_comb begin
        if (mul_sign) mul_out = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
        else          mul_out = {32'b0, mul_a} * {32'b0, mul_b};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: architectural effect of one op and its completion latency
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic dz);
        longint          sa, sb, sq, sr;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        lat = 0;
        case (o)
            3'd0: begin sq = sa * sb; m_hi = sq[63:32]; m_lo = sq[31:0]; lat = STAGES; end
            3'd1: begin up = longint'(a) * longint'(b); m_hi = up[63:32]; m_lo = up[31:0]; lat = STAGES; end
            3'd2, 3'd3: begin
                if (b == 0) begin
                    dz = 1'b1; lat = 1;
                end else begin
                    lat = 33;
                    if (o == 3'd2) begin
                        sq = sa / sb; sr = sa % sb;
                        m_lo = sq[31:0]; m_hi = sr[31:0];
                    end else begin
                        m_lo = a / b; m_hi = a % b;
                    end
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int   lat, n, nbusy;
        logic dz, seen;
        model(o, a, b, lat, dz);
        @(negedge clk);
        check("ready_before", 64'(op_ready), 64'(1));
        op_valid = 1'b1; op = o; op_a = a; op_b = b;
        @(posedge clk); #1;
        op_valid = 1'b0;
        if (lat == 0) begin
            check("nolat_busy", 64'(busy), 64'(0));
            check("nolat_done", 64'(done), 64'(0));
            check("nolat_hi", 64'(hi), 64'(m_hi));
            check("nolat_lo", 64'(lo), 64'(m_lo));
        end else begin
            n = 0; nbusy = 0; seen = 1'b0;
            while (!seen && n < 100) begin
                if (busy) nbusy++;
                @(posedge clk); #1;
                n++;
                if (done) seen = 1'b1;
            end
            check("latency", 64'(n), 64'(lat));
            check("busy_cycles", 64'(nbusy), 64'(lat));
            check("done_busy", 64'(busy), 64'(0));
            check("done_ready", 64'(op_ready), 64'(1));
            check("dz_flag", 64'(div_by_zero), 64'(dz));
            check("hi", 64'(hi), 64'(m_hi));
            check("lo", 64'(lo), 64'(m_lo));
            @(posedge clk); #1;
            check("done_pulse", 64'(done), 64'(0));
            check("dz_pulse", 64'(div_by_zero), 64'(0));
        end
    endtask

    initial begin
        int          n, ndone, lat;
        logic        dz;
        logic [31:0] a, b;
        logic [2:0]  o;

        reset = 1'b1; op_valid = 1'b0; op = '0; op_a = '0; op_b = '0;
        #2 reset = 1'b0;
        #1;
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ready", 64'(op_ready), 64'(1));
        check("rst_done", 64'(done), 64'(0));
        check("rst_dz", 64'(div_by_zero), 64'(0));
        check("rst_mul", {31'b0, mul_sign, mul_a ^ mul_b}, 64'(0));
        m_hi = '0; m_lo = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_op(3'd0, 32'hFFFF_FFFE, 32'h3);
        check("mult_hi_const", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo_const", 64'(lo), 64'hFFFF_FFFA);
        run_op(3'd1, 32'hFFFF_FFFE, 32'h3);
        check("multu_hi_const", 64'(hi), 64'h2);
        run_op(3'd2, 32'hFFFF_FFF9, 32'h2);
        check("div_lo_const", 64'(lo), 64'hFFFF_FFFD);
        check("div_hi_const", 64'(hi), 64'hFFFF_FFFF);
        run_op(3'd3, 32'd7, 32'd2);
        check("divu_lo_const", 64'(lo), 64'd3);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("ovf_lo_const", 64'(lo), 64'h8000_0000);
        check("ovf_hi_const", 64'(hi), 64'h0);
        run_op(3'd4, 32'h11, 32'h0);
        run_op(3'd5, 32'h22, 32'h0);
        run_op(3'd3, 32'd5, 32'd0);
        check("dz_keep", {hi, lo}, {32'h11, 32'h22});
        run_op(3'd6, 32'h5555, 32'h7);
        run_op(3'd7, 32'h5555, 32'h7);

        // MTHI while dividing is dropped; MTLO in the done cycle is taken
        model(3'd2, 32'd100, 32'd7, lat, dz);
        @(negedge clk);
        op_valid = 1'b1; op = 3'd2; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk); #1;
        op = 3'd4; op_a = 32'hABCD; op_b = '0;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("intf_latency", 64'(n), 64'(lat));
        check("intf_hi", 64'(hi), 64'd2);
        check("intf_ready", 64'(op_ready), 64'(1));
        op = 3'd5; op_a = 32'h1234;
        @(posedge clk); #1;
        op_valid = 1'b0;
        m_lo = 32'h1234;
        check("intf_mtlo", 64'(lo), 64'h1234);
        check("intf_hi_after", 64'(hi), 64'd2);

        // Reset in the middle of a division
        @(negedge clk);
        op_valid = 1'b1; op = 3'd2; op_a = 32'h1234_5678; op_b = 32'd3;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_hilo", {hi, lo}, 64'(0));
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("mid_rst_nodone", 64'(ndone), 64'(0));
        check("mid_rst_after", {hi, lo}, 64'(0));

        // Randomized ops against the reference model
        repeat (60) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 9))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'h8000_0000;
                3:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op(o, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
